// File: rtl/axi_arb_pkg.sv
// Shared types for the AW/AR arbiter mux: output-slice states, select-width helper
// and the one-hot seed used by the grant consistency check.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FULL  = 2'd1,
    OUT_SKID  = 2'd2
  } out_state_e;

  localparam int MAX_PORTS = 16;
  localparam logic [MAX_PORTS-1:0] GRANT_ONEHOT_LSB = MAX_PORTS'(1);

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_arb_out_slice.sv
// Registered output stage carrying the {sel, payload} bundle with valid/ready.
// With AXI_ARB_MUX_SKID_EN a skid register decouples o_free from i_ready.
//
// state     | meaning
// OUT_EMPTY | no beat held, o_valid low
// OUT_FULL  | main register holds the presented beat
// OUT_SKID  | main and skid both hold beats (skid build only)
module axi_arb_out_slice
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  out_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_main;

`ifdef AXI_ARB_MUX_SKID_EN
  logic [DATA_WIDTH-1:0] r_skid;

  assign o_free = (r_state != OUT_SKID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        OUT_EMPTY: if (i_valid) begin
          r_main  <= i_data;
          r_state <= OUT_FULL;
        end
        OUT_FULL: begin
          if (i_ready) begin
            if (i_valid) r_main <= i_data;
            else         r_state <= OUT_EMPTY;
          end else if (i_valid) begin
            r_skid  <= i_data;
            r_state <= OUT_SKID;
          end
        end
        OUT_SKID: if (i_ready) begin
          r_main  <= r_skid;
          r_state <= OUT_FULL;
        end
        default: r_state <= OUT_EMPTY;
      endcase
    end
  end
`else
  assign o_free = (r_state != OUT_FULL) | i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
      r_main  <= '0;
    end else begin
      case (r_state)
        OUT_EMPTY: if (i_valid) begin
          r_main  <= i_data;
          r_state <= OUT_FULL;
        end
        OUT_FULL: if (i_ready) begin
          if (i_valid) r_main <= i_data;
          else         r_state <= OUT_EMPTY;
        end
        default: r_state <= OUT_EMPTY;
      endcase
    end
  end
`endif

  assign o_valid = (r_state != OUT_EMPTY);
  assign o_data  = r_main;

endmodule

// File: rtl/axi_addr_arb_mux.sv
// AW/AR mux behind a TMR-voted arbiter: request masking, accept/ack, payload mux and
// sticky grant-consistency check. AXI_ARB_MUX_SKID_EN selects the skid output stage.
module axi_addr_arb_mux
  import axi_arb_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int SEL_WIDTH     = sel_width(S_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT-1:0]               s_valid,
  input  logic [S_COUNT*PAYLOAD_WIDTH-1:0] s_payload,
  output logic [S_COUNT-1:0]               s_ready,
  output logic                             m_valid,
  output logic [PAYLOAD_WIDTH-1:0]         m_payload,
  output logic [SEL_WIDTH-1:0]             m_sel,
  input  logic                             m_ready,
  output logic [S_COUNT-1:0]               arb_request,
  output logic [S_COUNT-1:0]               arb_acknowledge,
  input  logic [S_COUNT-1:0]               arb_grant,
  input  logic                             arb_grant_valid,
  input  logic [SEL_WIDTH-1:0]             arb_grant_encoded,
  output logic                             grant_err
);

  localparam int SLICE_W = SEL_WIDTH + PAYLOAD_WIDTH;

  logic [S_COUNT-1:0]       r_acc_mask;
  logic                     r_grant_err;
  logic                     w_enc_ok;
  logic                     w_sel_valid;
  logic [PAYLOAD_WIDTH-1:0] w_sel_payload;
  logic [S_COUNT-1:0]       w_sel_onehot;
  logic [S_COUNT-1:0]       w_exp_grant;
  logic                     w_grant_bad;
  logic                     w_out_free;
  logic                     w_acc;
  logic [SLICE_W-1:0]       w_slice_data;

  // An out-of-range encoded grant matches no port, so it can never be accepted.
  always_comb begin
    w_enc_ok      = 1'b0;
    w_sel_valid   = 1'b0;
    w_sel_payload = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (arb_grant_encoded == SEL_WIDTH'(i)) begin
        w_enc_ok      = 1'b1;
        w_sel_valid   = s_valid[i];
        w_sel_payload = s_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  assign w_sel_onehot = w_enc_ok ? (GRANT_ONEHOT_LSB[S_COUNT-1:0] << arb_grant_encoded) : '0;
  assign w_exp_grant  = arb_grant_valid ? w_sel_onehot : '0;
  assign w_grant_bad  = (arb_grant != w_exp_grant) | (arb_grant_valid & ~w_enc_ok);

  assign w_acc           = arb_grant_valid & w_sel_valid & w_out_free;
  assign s_ready         = w_acc ? w_sel_onehot : '0;
  assign arb_acknowledge = s_ready;
  assign arb_request     = s_valid & ~r_acc_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_mask  <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_acc_mask <= s_ready;
      if (w_grant_bad) r_grant_err <= 1'b1;
    end
  end

  assign grant_err = r_grant_err;

  axi_arb_out_slice #(
    .DATA_WIDTH(SLICE_W)
  ) u_out_slice (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(w_acc),
    .i_data ({arb_grant_encoded, w_sel_payload}),
    .o_free (w_out_free),
    .o_valid(m_valid),
    .o_data (w_slice_data),
    .i_ready(m_ready)
  );

  assign {m_sel, m_payload} = w_slice_data;

endmodule

// File: tb/tb_axi_addr_arb_mux.sv
// Directed bench for axi_addr_arb_mux: grant-vector table plus multi-cycle sequences,
// driven by a small round-robin arbiter model (blocking ack, registered grant).
`timescale 1ns/1ps
module tb_axi_addr_arb_mux;

  localparam int S  = 4;
  localparam int PW = 64;
  localparam int SW = 2;
`ifdef AXI_ARB_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S-1:0]    s_valid, s_ready, arb_request, arb_acknowledge, arb_grant;
  logic [S*PW-1:0] s_payload;
  logic            m_valid, m_ready, arb_grant_valid, grant_err;
  logic [PW-1:0]   m_payload;
  logic [SW-1:0]   m_sel, arb_grant_encoded;

  axi_addr_arb_mux #(.S_COUNT(S), .PAYLOAD_WIDTH(PW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_payload(s_payload), .s_ready(s_ready),
    .m_valid(m_valid), .m_payload(m_payload), .m_sel(m_sel), .m_ready(m_ready),
    .arb_request(arb_request), .arb_acknowledge(arb_acknowledge),
    .arb_grant(arb_grant), .arb_grant_valid(arb_grant_valid),
    .arb_grant_encoded(arb_grant_encoded), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit mdl_gv;
  int mdl_idx, mdl_last;
  bit ovr_en;

  logic [S-1:0]  sm_ready, sm_ack, sm_req;
  logic          sm_mv, sm_err;
  logic [SW-1:0] sm_sel;
  logic [PW-1:0] sm_pay;

  typedef struct {
    logic         gv;
    logic [S-1:0] g;
    logic [SW-1:0] e;
    logic [S-1:0] sv;
    logic [S-1:0] rdy;
    logic         err;
    logic         mv;
    logic [SW-1:0] sel;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pay(input logic [PW-1:0] base, input int p);
    return base + PW'(p);
  endfunction

  task automatic set_payloads(input logic [PW-1:0] base);
    for (int i = 0; i < S; i++) s_payload[i*PW +: PW] = pay(base, i);
  endtask

  task automatic drive_arb();
    if (!ovr_en) begin
      arb_grant_valid   = mdl_gv;
      arb_grant         = mdl_gv ? S'(1 << mdl_idx) : '0;
      arb_grant_encoded = SW'(mdl_idx);
    end
  endtask

  // Sample the current cycle at negedge, then advance to just after the next posedge.
  task automatic cycle();
    bit found;
    @(negedge clk);
    sm_ready = s_ready;  sm_ack = arb_acknowledge; sm_req = arb_request;
    sm_mv = m_valid;     sm_sel = m_sel;  sm_pay = m_payload; sm_err = grant_err;
    @(posedge clk);
    #1;
    s_valid = s_valid & ~sm_ready;
    if (!(mdl_gv && !sm_ack[mdl_idx] && sm_req[mdl_idx])) begin
      found  = 1'b0;
      mdl_gv = 1'b0;
      for (int k = 1; k <= S; k++) begin
        int p = (mdl_last + k) % S;
        if (!found && sm_req[p]) begin
          found = 1'b1; mdl_gv = 1'b1; mdl_idx = p; mdl_last = p;
        end
      end
    end
    drive_arb();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ovr_en = 1'b0; s_valid = '0; m_ready = 1'b1;
    mdl_gv = 1'b0; mdl_idx = 0; mdl_last = S - 1;
    drive_arb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int rcnt[S];
    int bp_cnt;

    s_valid = '0; s_payload = '0; m_ready = 1'b1; ovr_en = 1'b0;
    mdl_gv = 1'b0; mdl_idx = 0; mdl_last = S - 1;
    drive_arb();

    //        gv    grant    enc  s_valid  s_ready  err   mv    sel
    vt[0] = '{1'b1, 4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0};
    vt[1] = '{1'b1, 4'b1000, 2'd3, 4'b1111, 4'b1000, 1'b0, 1'b1, 2'd3};
    vt[2] = '{1'b1, 4'b0100, 2'd2, 4'b1011, 4'b0000, 1'b0, 1'b0, 2'd0};
    vt[3] = '{1'b0, 4'b0000, 2'd1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0};
    vt[4] = '{1'b0, 4'b0010, 2'd1, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0};
    vt[5] = '{1'b1, 4'b0011, 2'd0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[6] = '{1'b1, 4'b0010, 2'd3, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[7] = '{1'b1, 4'b0000, 2'd1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1};

    do_reset();
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_grant_err", 64'(grant_err), 64'(0));
    chk("rst_m_sel", 64'(m_sel), 64'(0));
    chk("rst_m_payload", m_payload, 64'(0));

    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_payloads(64'h7700_0000_0000_0000);
      ovr_en = 1'b1;
      arb_grant_valid = vt[v].gv; arb_grant = vt[v].g; arb_grant_encoded = vt[v].e;
      s_valid = vt[v].sv;
      cycle();
      chk("tv_s_ready", 64'(sm_ready), 64'(vt[v].rdy));
      chk("tv_ack", 64'(sm_ack), 64'(vt[v].rdy));
      chk("tv_request", 64'(sm_req), 64'(vt[v].sv));
      chk("tv_err_pre", 64'(sm_err), 64'(0));
      cycle();
      chk("tv_grant_err", 64'(sm_err), 64'(vt[v].err));
      chk("tv_m_valid", 64'(sm_mv), 64'(vt[v].mv));
      chk("tv_m_sel", 64'(sm_sel), 64'(vt[v].sel));
      chk("tv_m_payload", sm_pay, vt[v].mv ? pay(64'h7700_0000_0000_0000, int'(vt[v].sel)) : 64'(0));
    end

    // Single request on port 2
    do_reset();
    set_payloads(64'h1000);
    s_payload[2*PW +: PW] = 64'hA5;
    s_valid = 4'b0100;
    cycle();
    chk("single_c0_ready", 64'(sm_ready), 64'(0));
    cycle();
    chk("single_c1_ready", 64'(sm_ready), 64'(4'b0100));
    chk("single_c1_ack", 64'(sm_ack), 64'(4'b0100));
    chk("single_c1_mvalid", 64'(sm_mv), 64'(0));
    cycle();
    chk("single_c2_mvalid", 64'(sm_mv), 64'(1));
    chk("single_c2_payload", sm_pay, 64'hA5);
    chk("single_c2_sel", 64'(sm_sel), 64'(2));
    chk("single_c2_ready", 64'(sm_ready), 64'(0));
    cycle();
    chk("single_c3_mvalid", 64'(sm_mv), 64'(0));

    // All four ports, round robin
    do_reset();
    set_payloads(64'hB000);
    s_valid = 4'b1111;
    for (int i = 0; i < S; i++) rcnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      for (int i = 0; i < S; i++) rcnt[i] += int'(sm_ready[i]);
      if (c >= 2 && c <= 5) begin
        chk("rr_mvalid", 64'(sm_mv), 64'(1));
        chk("rr_sel", 64'(sm_sel), 64'(c - 2));
        chk("rr_payload", sm_pay, pay(64'hB000, c - 2));
      end else if (c >= 6) begin
        chk("rr_tail_mvalid", 64'(sm_mv), 64'(0));
      end
    end
    for (int i = 0; i < S; i++) chk("rr_ready_count", 64'(rcnt[i]), 64'(1));

    // Backpressure: m_ready low for five cycles with a beat held
    do_reset();
    set_payloads(64'hC000);
    m_ready = 1'b0;
    s_valid = 4'b0011;
    bp_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (c == 1) chk("bp_c1_ready", 64'(sm_ready), 64'(4'b0001));
      if (c >= 2) begin
        bp_cnt += (sm_ready != '0) ? 1 : 0;
        chk("bp_hold_mvalid", 64'(sm_mv), 64'(1));
        chk("bp_hold_sel", 64'(sm_sel), 64'(0));
        chk("bp_hold_payload", sm_pay, pay(64'hC000, 0));
      end
    end
    chk("bp_accepts_while_stalled", 64'(bp_cnt), 64'(SKID ? 1 : 0));
    m_ready = 1'b1;
    cycle();
    chk("bp_release_ready", 64'(sm_ready), SKID ? 64'(0) : 64'(4'b0010));
    chk("bp_release_sel", 64'(sm_sel), 64'(0));
    cycle();
    chk("bp_next_mvalid", 64'(sm_mv), 64'(1));
    chk("bp_next_sel", 64'(sm_sel), 64'(1));
    chk("bp_next_payload", sm_pay, pay(64'hC000, 1));
    cycle();
    chk("bp_drain_mvalid", 64'(sm_mv), 64'(0));

    // Granted port drops valid before acceptance
    do_reset();
    set_payloads(64'hE000);
    s_valid = 4'b0100;
    cycle();
    s_valid = 4'b0000;
    cycle();
    chk("drop_c1_ready", 64'(sm_ready), 64'(0));
    chk("drop_c1_ack", 64'(sm_ack), 64'(0));
    cycle();
    chk("drop_c2_mvalid", 64'(sm_mv), 64'(0));
    cycle();
    chk("drop_c3_mvalid", 64'(sm_mv), 64'(0));
    s_valid = 4'b0001;
    cycle();
    cycle();
    chk("drop_next_ready", 64'(sm_ready), 64'(4'b0001));
    cycle();
    chk("drop_next_mvalid", 64'(sm_mv), 64'(1));
    chk("drop_next_sel", 64'(sm_sel), 64'(0));
    chk("drop_next_payload", sm_pay, pay(64'hE000, 0));

    // Corrupted grant: sticky until asynchronous reset
    do_reset();
    ovr_en = 1'b1;
    arb_grant_valid = 1'b1; arb_grant = 4'b0011; arb_grant_encoded = 2'd0;
    cycle();
    chk("corrupt_c0_err", 64'(sm_err), 64'(0));
    arb_grant_valid = 1'b0; arb_grant = 4'b0000;
    cycle();
    chk("corrupt_c1_err", 64'(sm_err), 64'(1));
    cycle();
    cycle();
    chk("corrupt_sticky_err", 64'(sm_err), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("corrupt_async_clear", 64'(grant_err), 64'(0));

    // Asynchronous reset mid-burst
    do_reset();
    set_payloads(64'hF000);
    s_valid = 4'b1111;
    cycle();
    cycle();
    cycle();
    chk("arst_pre_mvalid", 64'(sm_mv), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 64'(m_valid), 64'(0));
    chk("arst_payload", m_payload, 64'(0));
    chk("arst_sel", 64'(m_sel), 64'(0));
    chk("arst_err", 64'(grant_err), 64'(0));
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
